// File: rtl/shift_sequencer.sv
// Multicycle shifter: latches operand, amount and op on start, then applies one
// 1-bit SLL/SRL/SRA/ROR step per cycle, reporting busy while shifting and a done pulse.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] shift_step(input op_e o, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = {d[0], d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every *_d gets a default up front so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    cnt_d   = shamt;
                    op_d    = op_e'(op);
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = shift_step(op_q, data_q);
                // Count stops at zero; a count of one means this edge applies the last step.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= 1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state flops.
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update
        // together from the values present before the edge.
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, random ops against an
// arithmetic reference model, plus ignored-start and mid-shift reset sequences.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Whole-amount shift computed directly; ROR built from two shifts.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int s);
        case (o)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the
    // posedge following the done cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] exp);
        int   lat;
        logic busy_bad;
        start = 1'b1; op = o; data_in = d; shamt = s;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); data_in = $urandom; shamt = 5'($urandom);
        lat = 1;
        busy_bad = 1'b0;
        while (!done && lat <= 40) begin
            if (busy !== (s != 0)) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, int'(s) + 1);
        check({name, " data"}, data_out, exp);
        check({name, " busy during shift"}, {31'd0, busy_bad}, 32'd0);
        check({name, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({name, " held"}, data_out, exp);
        check({name, " idle flags"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vec_t        tbl[7];
        int          lat;
        logic        seen;
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [4:0]  rs;

        tbl[0] = '{"sll16",   2'd0, 32'h0000_0001, 5'd16, 32'h0001_0000};
        tbl[1] = '{"sra4",    2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000};
        tbl[2] = '{"srl4",    2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000};
        tbl[3] = '{"ror31",   2'd3, 32'h0000_0001, 5'd31, 32'h0000_0002};
        tbl[4] = '{"zero",    2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        tbl[5] = '{"sra31p",  2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        tbl[6] = '{"sll31",   2'd0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};

        reset = 1'b1; start = 1'b0; op = 2'd0; data_in = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset data", data_out, 32'd0);
        check("reset flags", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op(tbl[i].name, tbl[i].op, tbl[i].data, tbl[i].sh, tbl[i].exp);

        // Start pulsed mid-shift must be ignored.
        start = 1'b1; op = 2'd0; data_in = 32'h1; shamt = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat <= 40) begin
            if (lat == 3) begin
                start = 1'b1; op = 2'd2; data_in = 32'hFFFF_FFFF; shamt = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("ignore latency", lat, 32'd9);
        check("ignore data", data_out, 32'h0000_0100);
        @(posedge clk); #1;
        run_op("after ignore", 2'd1, 32'h0000_00F0, 5'd4, 32'h0000_000F);

        // Reset during a 20-step shift aborts with no done pulse.
        start = 1'b1; op = 2'd0; data_in = 32'h0000_0003; shamt = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort data", data_out, 32'd0);
        check("abort flags", {30'd0, busy, done}, 32'd0);
        for (int c = 0; c < 25; c++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom_range(3));
            rd = $urandom;
            rs = 5'($urandom_range(31));
            run_op($sformatf("rand%0d", k), ro, rd, rs, ref_shift(ro, rd, int'(rs)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
